// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI byte shifter: FSM states, transfer
// constants and the MISO line select.
package spi_shift_engine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    TRAIL = 2'd2
  } spi_state_t;

  localparam int SPI_HALF_PERIODS = 16;

  // Slave selects are active-low; MISO[2] answers when neither select is driven.
  function automatic logic misox_sel(input logic [2:0] miso, input logic [1:0] nss);
    return (miso[0] & ~nss[0]) | (miso[1] & ~nss[1]) | (miso[2] & nss[0] & nss[1]);
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Control/data bus between the ctrl-code decoder and the SPI shift engine,
// including the SPI device pins.
interface spi_shift_engine_if #(parameter int DIV_W = 4);
  logic             start;
  logic [7:0]       txd;
  logic             cpol;
  logic             ss_we;
  logic [1:0]       ss_d;
  logic [DIV_W-1:0] div;
  logic [2:0]       miso;
  logic             sck;
  logic             mosi;
  logic [1:0]       nss;
  logic [7:0]       rxd;
  logic             busy;
  logic             done;

  modport master (
    output start, txd, cpol, ss_we, ss_d, div, miso,
    input  sck, mosi, nss, rxd, busy, done
  );

  modport slave (
    input  start, txd, cpol, ss_we, ss_d, div, miso,
    output sck, mosi, nss, rxd, busy, done
  );
endinterface

// File: rtl/spi_shift_engine_tick_div.sv
// Half-period divider: loadable down-counter that fires a tick when it hits
// zero and then reloads from the latched divide value.
module spi_tick_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic [DIV_W-1:0] reload_val,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      if (cnt == '0) cnt <= reload_val;
      else           cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// CPHA=0 SPI byte shifter: one START strobe sends TXD MSB-first on MOSI while
// collecting the selected MISO line into RXD.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int DIV_W = 4,
  parameter int NBITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  spi_shift_engine_if.slave  bus
);

  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_HALF_PERIODS / 2 - 1);

  spi_state_t       state, state_n;
  logic             sck, mosi, done, cpol_l;
  logic [1:0]       nss;
  logic [NBITS-1:0] rxd, rx_sr;
  logic [NBITS-2:0] tx_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_l;
  logic             tick, go, lead_tick, trail_tick, last_bit, finish, misox;

  assign misox = misox_sel(bus.miso, nss);

  spi_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load       (go),
    .load_val   (bus.div),
    .reload_val (div_l),
    .en         (state != IDLE),
    .tick       (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    go         = 1'b0;
    lead_tick  = 1'b0;
    trail_tick = 1'b0;
    last_bit   = (bit_cnt == LAST_BIT);
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        go = bus.start;
        if (bus.start) state_n = LEAD;
      end
      LEAD: begin
        lead_tick = tick;
        if (tick) state_n = TRAIL;
      end
      TRAIL: begin
        trail_tick = tick;
        finish     = tick && last_bit;
        if (tick) state_n = last_bit ? IDLE : LEAD;
      end
      default: state_n = IDLE;
    endcase
  end

  // nSS only moves between bytes so a device never sees its select glitch mid-transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck     <= 1'b0;
      mosi    <= 1'b0;
      nss     <= 2'b11;
      rxd     <= '0;
      done    <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      cpol_l  <= 1'b0;
      div_l   <= '0;
    end else begin
      done <= finish;
      if (state == IDLE && bus.ss_we) nss <= bus.ss_d;
      if (go) begin
        tx_sr   <= bus.txd[NBITS-2:0];
        rx_sr   <= '0;
        mosi    <= bus.txd[NBITS-1];
        cpol_l  <= bus.cpol;
        div_l   <= bus.div;
        sck     <= bus.cpol;
        bit_cnt <= '0;
      end
      if (lead_tick) begin
        sck   <= ~cpol_l;
        rx_sr <= {rx_sr[NBITS-2:0], misox};
      end
      if (trail_tick) begin
        sck <= cpol_l;
        if (last_bit) begin
          rxd <= rx_sr;
        end else begin
          mosi    <= tx_sr[NBITS-2];
          tx_sr   <= {tx_sr[NBITS-3:0], 1'b0};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.sck  = sck;
  assign bus.mosi = mosi;
  assign bus.nss  = nss;
  assign bus.rxd  = rxd;
  assign bus.busy = (state != IDLE);
  assign bus.done = done;

endmodule
